// File: rtl/icache_dm.sv
// icache_dm -- direct-mapped, one-word-per-line instruction cache.
//
// Sits between the instruction fetcher and the memory controller's
// instruction-read port. Hits answer one cycle after acceptance; misses
// issue a word-aligned read, wait for mc_done, fill the line and answer.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rdy             global ready; 0 freezes every register
//   if_req, if_pc   fetch request and address (pc[1:0] ignored)
//   if_ready        request can be accepted (IDLE only)
//   if_inst_valid   one-cycle response pulse, if_inst valid
//   if_inst         returned instruction
//   flush           cancel the pending response (branch redirect)
//   mc_valid        miss read request, held until mc_done
//   mc_addr         word-aligned miss address
//   mc_done, mc_inst  fill pulse and fetched word
//   dbg_state       current FSM state, for checkers
//
// Optional feature: define ICACHE_FORWARD_EN to forward mc_inst to the
// fetcher in the mc_done cycle and skip the RESP state.
//
// Handshake: a request transfers on a clock edge where if_ready, if_req
// and rdy are high and flush is low. mc_valid/mc_addr stay constant from
// the first cycle mc_valid is high up to and including the cycle mc_done
// is sampled high; if_inst_valid is a pulse with no back-pressure.
module icache_dm #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        if_inst_valid,
  output logic [31:0] if_inst,
  input  logic        flush,
  output logic        mc_valid,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_inst,
  output logic [1:0]  dbg_state
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESP} state_t;

  state_t state, state_nx;

  logic [29:0]           pc_q;      // accepted pc[31:2]
  logic                  cancel_q;  // flush seen while the miss was outstanding
  logic                  init_q;    // holds if_ready low until the first edge out of reset
  logic [LINES-1:0]      valid_q;
  logic [31:0]           data_mem [LINES];
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic                  mc_valid_q;
  logic [31:0]           mc_addr_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  accept, miss_issue, fill, set_cancel, rsp;
`ifdef ICACHE_FORWARD_EN
  logic                  rsp_fwd;
`endif

  // Byte offset of the fetch address has no meaning for a word cache.
  logic unused_pc_bits;
  assign unused_pc_bits = ^if_pc[1:0];

  assign idx = pc_q[INDEX_BITS-1:0];
  assign tag = pc_q[29:INDEX_BITS];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  assign if_ready  = (state == IDLE) && init_q;
  assign mc_valid  = mc_valid_q;
  assign mc_addr   = mc_addr_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and per-cycle strobes. Every strobe is gated by rdy so a
  // stalled cycle changes nothing and drops the response pulse.
  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    miss_issue    = 1'b0;
    fill          = 1'b0;
    set_cancel    = 1'b0;
    rsp           = 1'b0;
`ifdef ICACHE_FORWARD_EN
    rsp_fwd       = 1'b0;
`endif
    if (rdy) begin
      case (state)
        IDLE: begin
          if (init_q && if_req && !flush) begin
            accept   = 1'b1;
            state_nx = LOOKUP;
          end
        end
        LOOKUP: begin
          if (flush) begin
            state_nx = IDLE;
          end else if (hit) begin
            rsp      = 1'b1;
            state_nx = IDLE;
          end else begin
            miss_issue = 1'b1;
            state_nx   = MISS;
          end
        end
        MISS: begin
          // The read is never withdrawn; a flush only kills the answer.
          if (flush) set_cancel = 1'b1;
          if (mc_done) begin
            fill = 1'b1;
            if (cancel_q || flush) begin
              state_nx = IDLE;
            end else begin
`ifdef ICACHE_FORWARD_EN
              rsp_fwd  = 1'b1;
              state_nx = IDLE;
`else
              state_nx = RESP;
`endif
            end
          end
        end
        RESP: begin
          if (!flush) rsp = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    if_inst_valid = rsp;
    if_inst       = '0;
    if (rsp) if_inst = data_mem[idx];
`ifdef ICACHE_FORWARD_EN
    if (rsp_fwd) begin
      if_inst_valid = 1'b1;
      if_inst       = mc_inst;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      cancel_q   <= 1'b0;
      init_q     <= 1'b0;
      valid_q    <= '0;
      mc_valid_q <= 1'b0;
      mc_addr_q  <= '0;
    end else begin
      if (rdy) init_q <= 1'b1;
      if (accept) pc_q <= if_pc[31:2];
      if (miss_issue) begin
        mc_valid_q <= 1'b1;
        mc_addr_q  <= {pc_q, 2'b00};
      end
      if (fill) begin
        mc_valid_q   <= 1'b0;
        valid_q[idx] <= 1'b1;
      end
      if (set_cancel) cancel_q <= 1'b1;
      if (rdy && state_nx == IDLE) cancel_q <= 1'b0;
    end
  end

  // Line storage needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[idx] <= mc_inst;
      tag_mem[idx]  <= tag;
    end
  end

endmodule
